// File: rtl/xlink_rx_phy_2b.sv
// Two-wire transition-coded link receiver: 8-bit payload, control flag and balance bit per token.
// Define XLINK_RX_BALANCE_CHECK_EN to reject tokens whose balance bit is inconsistent.
module xlink_rx_phy_2b (
  input  logic       clk,
  input  logic       async_reset_n,
  input  logic       rx_0,
  input  logic       rx_1,
  input  logic [7:0] bit_timeout,
  output logic [8:0] rx_token,
  output logic       rx_token_valid,
  input  logic       rx_token_taken,
  output logic       rx_error,
  output logic       rx_overrun
);

  typedef enum logic {StIdle, StRecv} state_e;

  // [0],[1] form the synchroniser, [2] holds the previous synchronised value
  logic [2:0] sync0_q, sync1_q;
  logic [1:0] warm_q;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] idle_q, idle_d;
  logic [8:0] shift_q, shift_d;
  logic [8:0] token_q, token_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       ovr_q, ovr_d;

  logic edge0, edge1, single, both, bit_v, load;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync0_q <= 3'b0;
      sync1_q <= 3'b0;
      warm_q  <= 2'd0;
    end else begin
      sync0_q <= {sync0_q[1:0], rx_0};
      sync1_q <= {sync1_q[1:0], rx_1};
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // Edges are masked until the synchroniser has filled with the real wire levels
  assign edge0  = (warm_q == 2'd3) && (sync0_q[1] ^ sync0_q[2]);
  assign edge1  = (warm_q == 2'd3) && (sync1_q[1] ^ sync1_q[2]);
  assign single = edge0 ^ edge1;
  assign both   = edge0 & edge1;
  assign bit_v  = edge1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    shift_d = shift_q;
    token_d = token_q;
    valid_d = valid_q & ~rx_token_taken;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    load    = 1'b0;
    if (both) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
      idle_d  = 8'd0;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (single) begin
            state_d = StRecv;
            cnt_d   = 4'd1;
            idle_d  = 8'd0;
            shift_d = {8'b0, bit_v};
          end
        end
        StRecv: begin
          if (single) begin
            idle_d = 8'd0;
            if (cnt_q == 4'd9) begin
              state_d = StIdle;
              cnt_d   = 4'd0;
`ifdef XLINK_RX_BALANCE_CHECK_EN
              // shift_q holds payload and control flag, so its parity is the expected balance
              if (bit_v == ^shift_q) load = 1'b1;
              else err_d = 1'b1;
`else
              load = 1'b1;
`endif
            end else begin
              cnt_d   = cnt_q + 4'd1;
              shift_d = {shift_q[7:0], bit_v};
            end
          end else if (bit_timeout != 8'd0) begin
            idle_d = idle_q + 8'd1;
            if (idle_d == bit_timeout) begin
              state_d = StIdle;
              cnt_d   = 4'd0;
              idle_d  = 8'd0;
              err_d   = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (load) begin
      token_d = {shift_q[0], shift_q[8:1]};
      valid_d = 1'b1;
      ovr_d   = valid_q & ~rx_token_taken;
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idle_q  <= 8'd0;
      shift_q <= 9'd0;
      token_q <= 9'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      shift_q <= shift_d;
      token_q <= token_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_token       = token_q;
  assign rx_token_valid = valid_q;
  assign rx_error       = err_q;
  assign rx_overrun     = ovr_q;

endmodule

// File: tb/tb_xlink_rx_phy_2b.sv
// Self-checking bench for xlink_rx_phy_2b: scoreboard of expected tokens plus directed checks.
module tb_xlink_rx_phy_2b;

  logic       clk = 1'b0;
  logic       async_reset_n = 1'b1;
  logic       rx_0 = 1'b0;
  logic       rx_1 = 1'b0;
  logic [7:0] bit_timeout = 8'd0;
  logic [8:0] rx_token;
  logic       rx_token_valid;
  logic       rx_token_taken = 1'b0;
  logic       rx_error;
  logic       rx_overrun;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  logic [8:0] sb_q[$];

  always #5 clk = ~clk;

  xlink_rx_phy_2b dut (
    .clk            (clk),
    .async_reset_n  (async_reset_n),
    .rx_0           (rx_0),
    .rx_1           (rx_1),
    .bit_timeout    (bit_timeout),
    .rx_token       (rx_token),
    .rx_token_valid (rx_token_valid),
    .rx_token_taken (rx_token_taken),
    .rx_error       (rx_error),
    .rx_overrun     (rx_overrun)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor: every newly presented token is compared against the scoreboard
  logic       prev_v = 1'b0;
  logic [8:0] prev_t = 9'd0;
  always @(negedge clk) begin
    if (rx_error) err_cnt++;
    if (rx_overrun) ovr_cnt++;
    if (rx_token_valid && (!prev_v || rx_token != prev_t)) begin
      if (sb_q.size() == 0) check("sb_extra", {23'b0, rx_token}, 32'h200);
      else check("sb_token", {23'b0, rx_token}, {23'b0, sb_q.pop_front()});
    end
    prev_v = rx_token_valid;
    prev_t = rx_token;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input int gap);
    if (b) rx_1 = ~rx_1;
    else rx_0 = ~rx_0;
    tick(gap);
  endtask

  function automatic logic good_bal(input logic [7:0] p, input logic ctl);
    return ctl ^ (^p);
  endfunction

  // take_end raises rx_token_taken in exactly the cycle the balance edge is consumed
  task automatic send_token(input logic [7:0] p, input logic ctl, input logic bal, input int gap,
                            input bit take_end, input bit expect_ok);
    for (int i = 7; i >= 0; i--) send_bit(p[i], gap);
    send_bit(ctl, gap);
    if (expect_ok) sb_q.push_back({ctl, p});
    if (take_end) begin
      send_bit(bal, 2);
      rx_token_taken = 1'b1;
      tick(1);
      rx_token_taken = 1'b0;
    end else begin
      send_bit(bal, gap);
    end
  endtask

  task automatic take(input string tag);
    check({tag, "_valid_pre"}, {31'b0, rx_token_valid}, 32'd1);
    rx_token_taken = 1'b1;
    tick(1);
    rx_token_taken = 1'b0;
    check({tag, "_valid_post"}, {31'b0, rx_token_valid}, 32'd0);
  endtask

  int e0, o0;
  bit bad_ok;

  initial begin
    #1 async_reset_n = 1'b0;
    #1;
    check("rst_token", {23'b0, rx_token}, 32'd0);
    check("rst_valid", {31'b0, rx_token_valid}, 32'd0);
    check("rst_error", {31'b0, rx_error}, 32'd0);
    check("rst_overrun", {31'b0, rx_overrun}, 32'd0);
    tick(2);
    async_reset_n = 1'b1;
    tick(6);

    // DATA 0xA5
    e0 = err_cnt; o0 = ovr_cnt;
    send_token(8'hA5, 1'b0, good_bal(8'hA5, 1'b0), 1, 1'b0, 1'b1);
    tick(5);
    check("a5_token", {23'b0, rx_token}, 32'h0A5);
    check("a5_err", err_cnt - e0, 0);
    take("a5");

    // CTL 0x01, consistent balance
    send_token(8'h01, 1'b1, 1'b0, 1, 1'b0, 1'b1);
    tick(5);
    check("ctl_token", {23'b0, rx_token}, 32'h101);
    take("ctl");

    // CTL 0x01, inconsistent balance
    e0 = err_cnt;
`ifdef XLINK_RX_BALANCE_CHECK_EN
    bad_ok = 1'b0;
`else
    bad_ok = 1'b1;
`endif
    send_token(8'h01, 1'b1, 1'b1, 1, 1'b0, bad_ok);
    tick(5);
    check("bal_err", err_cnt - e0, bad_ok ? 0 : 1);
    check("bal_valid", {31'b0, rx_token_valid}, {31'b0, bad_ok});
    if (bad_ok) take("bal");

    // Timeout mid-token, then a full token at the same setting
    bit_timeout = 8'd5;
    e0 = err_cnt;
    for (int i = 0; i < 4; i++) send_bit(i[0], 2);
    tick(14);
    check("to_err", err_cnt - e0, 1);
    check("to_valid", {31'b0, rx_token_valid}, 32'd0);
    e0 = err_cnt;
    send_token(8'hFF, 1'b0, good_bal(8'hFF, 1'b0), 2, 1'b0, 1'b1);
    tick(5);
    check("ff_token", {23'b0, rx_token}, 32'h0FF);
    check("ff_err", err_cnt - e0, 0);
    take("ff");
    bit_timeout = 8'd0;

    // Overrun: two tokens without consumption
    e0 = err_cnt; o0 = ovr_cnt;
    send_token(8'h12, 1'b0, good_bal(8'h12, 1'b0), 1, 1'b0, 1'b1);
    tick(5);
    send_token(8'h34, 1'b0, good_bal(8'h34, 1'b0), 1, 1'b0, 1'b1);
    tick(5);
    check("ovr_count", ovr_cnt - o0, 1);
    check("ovr_token", {23'b0, rx_token}, 32'h034);
    check("ovr_err", err_cnt - e0, 0);
    take("ovr");

    // Token completes in the same cycle the previous one is taken
    o0 = ovr_cnt;
    send_token(8'h56, 1'b0, good_bal(8'h56, 1'b0), 1, 1'b0, 1'b1);
    tick(5);
    send_token(8'h78, 1'b1, good_bal(8'h78, 1'b1), 1, 1'b1, 1'b1);
    check("same_valid", {31'b0, rx_token_valid}, 32'd1);
    check("same_token", {23'b0, rx_token}, 32'h178);
    tick(3);
    check("same_ovr", ovr_cnt - o0, 0);
    take("same");

    // Reset mid-token with wires forced high
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) send_bit(i[0], 1);
    async_reset_n = 1'b0;
    rx_0 = 1'b1;
    rx_1 = 1'b1;
    #1;
    check("mid_rst_token", {23'b0, rx_token}, 32'd0);
    check("mid_rst_valid", {31'b0, rx_token_valid}, 32'd0);
    tick(3);
    async_reset_n = 1'b1;
    tick(8);
    check("post_rst_err", err_cnt - e0, 0);
    check("post_rst_valid", {31'b0, rx_token_valid}, 32'd0);
    send_token(8'h3C, 1'b0, good_bal(8'h3C, 1'b0), 1, 1'b0, 1'b1);
    tick(5);
    check("3c_token", {23'b0, rx_token}, 32'h03C);
    check("3c_err", err_cnt - e0, 0);
    take("3c");

    tick(4);
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xlink_rx_phy_2b.md
XLINK_RX_PHY_2B -- requirements
Module: xlink_rx_phy_2b

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state on its rising edge.
REQ-002 SHALL have port: async_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: rx_0  in  1  receive 0-wire, asynchronous to clk; a transition encodes a 0 bit.
REQ-004 SHALL have port: rx_1  in  1  receive 1-wire, asynchronous to clk; a transition encodes a 1 bit.
REQ-005 SHALL have port: bit_timeout  in  8  static config; max idle cycles between bits within a token; 0 disables the timeout.
REQ-006 SHALL have port: rx_token  out  9  received token; bit 8 = control flag, bits 7:0 = payload.
REQ-007 SHALL have port: rx_token_valid  out  1  rx_token holds an unconsumed token.
REQ-008 SHALL have port: rx_token_taken  in  1  consumer accepts rx_token this cycle.
REQ-009 SHALL have port: rx_error  out  1  one-cycle pulse on any framing error.
REQ-010 SHALL have port: rx_overrun  out  1  one-cycle pulse when an unconsumed token is overwritten.

Function
REQ-011 SHALL pass each of rx_0 and rx_1 through a 2-flop synchroniser, then a third flop; an edge is a synchronised value differing from its third-flop copy.
REQ-012 SHALL decode a token as 10 edges, first edge = token bit 7, descending to bit 0 at edge 8; edge 9 = control flag; edge 10 = balance bit.
REQ-013 SHALL treat balance bit as consistent when it equals control flag XOR (XOR-reduction of payload bits 7:0).
REQ-014 SHALL use FSM states IDLE and RECV plus a 4-bit edge counter; IDLE->RECV on first single edge (counter=1); RECV increments counter per single edge.
REQ-015 SHALL on the 10th edge return to IDLE and, if the token is accepted, load rx_token and assert rx_token_valid in the next cycle.
REQ-016 SHALL treat edges on both wires in the same cycle as an error in either state: discard partial token, go IDLE, pulse rx_error next cycle.
REQ-017 SHALL, in RECV with bit_timeout!=0, count consecutive edge-free cycles (8-bit counter, cleared on each edge); on reaching bit_timeout, discard partial token, go IDLE, pulse rx_error next cycle.
REQ-018 SHALL hold rx_token_valid high until a cycle with rx_token_taken high, then deassert next cycle; rx_token_taken while valid is low is ignored.
REQ-019 SHALL, when a token completes in the same cycle rx_token_taken is high, keep rx_token_valid high and present the new token.
REQ-020 SHALL, when a token completes while valid is high and rx_token_taken low, overwrite rx_token, keep valid high, pulse rx_overrun.
REQ-021 SHALL keep rx_token stable whenever no new token is loaded.
REQ-022 SHALL suppress edge detection for the first 3 cycles after reset deassertion, so the idle level of the wires produces no spurious edge.

Reset
REQ-023 SHALL on async_reset_n low immediately clear all synchroniser flops, FSM to IDLE, counters to 0, rx_token=0, rx_token_valid=0, rx_error=0, rx_overrun=0.
REQ-024 SHALL discard any partial token on reset mid-reception, with no error or valid generated for it.

Configuration
REQ-025 SHALL provide macro XLINK_RX_BALANCE_CHECK_EN; when defined, an inconsistent balance bit discards the token, keeps rx_token_valid and rx_token unchanged, and pulses rx_error.
REQ-026 SHALL, without XLINK_RX_BALANCE_CHECK_EN, ignore the balance bit and deliver every 10-edge token; REQ-016/017 errors remain active.

Verification
REQ-027 SHALL cover: DATA 0xA5 sent as wire edges 1,0,1,0,0,1,0,1,0,0 -> rx_token=0x0A5, valid high, no error.
REQ-028 SHALL cover: CTL 0x01 sent with trailing 1,0 -> rx_token=0x101, valid high; taken pulse -> valid low next cycle.
REQ-029 SHALL cover: CTL 0x01 sent with trailing 1,1 -> macro defined: rx_error pulse, valid stays low; macro undefined: rx_token=0x101 delivered.
REQ-030 SHALL cover: bit_timeout=5, 4 edges then 5 idle cycles -> rx_error pulse; following full DATA 0xFF -> rx_token=0x0FF.
REQ-031 SHALL cover: DATA 0x12 then DATA 0x34, taken held low -> rx_overrun pulse once, rx_token=0x034, valid high.
REQ-032 SHALL cover: reset asserted after 6 edges with wires at nonzero levels -> all outputs 0; after release, DATA 0x3C -> rx_token=0x03C, no error.
